// File: rtl/stepper_ctrl_xy_if.sv
// Command/status handshake between the command processor (master) and the
// two-axis stepper controller (slave).
interface stepper_ctrl_xy_if #(
  parameter int PULSE_NUM_X_BITS = 8,
  parameter int PULSE_NUM_Y_BITS = 8,
  parameter int PULSE_WIDTH_BITS = 8
);
  logic [PULSE_NUM_X_BITS-1:0] pulse_num_x;
  logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
  logic [PULSE_WIDTH_BITS-1:0] pulse_width;
  logic                        trigger;
  logic                        done;
  logic                        rdy;

  modport master (
    output pulse_num_x, pulse_num_y, pulse_width, trigger,
    input  done, rdy
  );

  modport slave (
    input  pulse_num_x, pulse_num_y, pulse_width, trigger,
    output done, rdy
  );
endinterface

// File: rtl/stepper_ctrl_xy.sv
// Two-axis stepper pulse generator: latches a move command on trigger and
// runs independent X/Y step trains of equal high/low phase length.

module stepper_ctrl_xy_axis #(
  parameter int CNT_BITS         = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [CNT_BITS-1:0]         count,
  input  logic [PULSE_WIDTH_BITS-1:0] width,
  input  logic                        tick,
  output logic                        step,
  output logic                        finished,
  output logic                        finishing
);
  logic [CNT_BITS-1:0]         rem;
  logic [PULSE_WIDTH_BITS-1:0] phase;
  logic [PULSE_WIDTH_BITS-1:0] phase_inc;
  logic                        level;
  logic                        active;
  logic                        phase_end;

  assign phase_inc = phase + PULSE_WIDTH_BITS'(1);
  assign phase_end = (phase_inc == width);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem    <= '0;
      phase  <= '0;
      level  <= 1'b0;
      active <= 1'b0;
    end else if (load) begin
      rem    <= count;
      phase  <= '0;
      level  <= (count != '0);
      active <= (count != '0);
    end else if (active && tick) begin
      if (phase_end) begin
        phase <= '0;
        // Count drops on the falling edge; the axis retires at the end of
        // the low phase that follows its last pulse.
        if (level) begin
          level <= 1'b0;
          rem   <= rem - CNT_BITS'(1);
        end else if (rem == '0) begin
          active <= 1'b0;
        end else begin
          level <= 1'b1;
        end
      end else begin
        phase <= phase_inc;
      end
    end
  end

  assign step      = level;
  assign finished  = !active;
  assign finishing = active && tick && !level && phase_end && (rem == '0);
endmodule

module stepper_ctrl_xy #(
  parameter int PULSE_NUM_X_BITS = 8,
  parameter int PULSE_NUM_Y_BITS = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  stepper_ctrl_xy_if.slave  bus,
  output logic              step_x,
  output logic              step_y
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic                        accept;
  logic                        both_zero;
  logic [PULSE_WIDTH_BITS-1:0] width_lat;
  logic                        x_finished, x_finishing;
  logic                        y_finished, y_finishing;
  logic                        x_end, y_end;

  assign accept    = (state == IDLE) && bus.trigger;
  assign both_zero = (bus.pulse_num_x == '0) && (bus.pulse_num_y == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      width_lat <= '0;
    end else if (accept) begin
      width_lat <= (bus.pulse_width == '0) ? PULSE_WIDTH_BITS'(1) : bus.pulse_width;
    end
  end

  stepper_ctrl_xy_axis #(
    .CNT_BITS         (PULSE_NUM_X_BITS),
    .PULSE_WIDTH_BITS (PULSE_WIDTH_BITS)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .count     (bus.pulse_num_x),
    .width     (width_lat),
    .tick      (clk_en),
    .step      (step_x),
    .finished  (x_finished),
    .finishing (x_finishing)
  );

  stepper_ctrl_xy_axis #(
    .CNT_BITS         (PULSE_NUM_Y_BITS),
    .PULSE_WIDTH_BITS (PULSE_WIDTH_BITS)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .count     (bus.pulse_num_y),
    .width     (width_lat),
    .tick      (clk_en),
    .step      (step_y),
    .finished  (y_finished),
    .finishing (y_finishing)
  );

  // Look ahead one edge so DONE lands in the cycle right after the last low phase.
  assign x_end = x_finished || x_finishing;
  assign y_end = y_finished || y_finishing;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.trigger) state_next = both_zero ? DONE : RUN;
      RUN:  if (x_end && y_end) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.rdy  = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: bus.rdy  = 1'b1;
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_stepper_ctrl_xy.sv
// Directed self-checking bench for stepper_ctrl_xy; cycle 0 is the cycle in
// which trigger is presented, outputs are sampled 1 time unit after each edge.
module tb_stepper_ctrl_xy;
  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic step_x;
  logic step_y;
  int   tests_run = 0;
  int   tests_failed = 0;

  stepper_ctrl_xy_if #(
    .PULSE_NUM_X_BITS (8),
    .PULSE_NUM_Y_BITS (8),
    .PULSE_WIDTH_BITS (8)
  ) bus ();

  stepper_ctrl_xy #(
    .PULSE_NUM_X_BITS (8),
    .PULSE_NUM_Y_BITS (8),
    .PULSE_WIDTH_BITS (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus),
    .step_x (step_x),
    .step_y (step_y)
  );

  always #5 clk = ~clk;

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] nx, input logic [7:0] ny, input logic [7:0] w);
    bus.pulse_num_x = nx;
    bus.pulse_num_y = ny;
    bus.pulse_width = w;
    bus.trigger     = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    reset = 1'b1;
    clk_en = 1'b1;
    bus.trigger = 1'b0;
    bus.pulse_num_x = '0;
    bus.pulse_num_y = '0;
    bus.pulse_width = '0;
    next_cyc;
    next_cyc;
    got = {bus.rdy, bus.done, step_y, step_x};
    tests_run++;
    if (got !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_held: got %b expected 1000 (rdy,done,y,x)", got);
    end
    reset = 1'b0;
    next_cyc;
    got = {bus.rdy, bus.done, step_y, step_x};
    tests_run++;
    if (got !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected 1000 (rdy,done,y,x)", got);
    end
  endtask

  task automatic test_basic;
    logic [31:0] xm, ym, dm, rm;
    logic [3:0]  got, exp_v;
    xm = 32'h0000_0666;
    ym = 32'h0000_0066;
    dm = 32'h0000_2000;
    rm = 32'h0000_C000;
    issue(8'd3, 8'd2, 8'd2);
    for (int c = 1; c <= 15; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], ym[c], xm[c]};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL basic cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
  endtask

  task automatic test_zero_counts;
    logic [31:0] dm, rm;
    logic [3:0]  got, exp_v;
    dm = 32'h0000_0002;
    rm = 32'h0000_000C;
    issue(8'd0, 8'd0, 8'd5);
    for (int c = 1; c <= 3; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], 2'b00};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL zero_counts cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
  endtask

  task automatic test_width_zero;
    logic [31:0] sm, dm, rm;
    logic [3:0]  got, exp_v;
    sm = 32'h0000_0002;
    dm = 32'h0000_0008;
    rm = 32'h0000_0030;
    issue(8'd1, 8'd1, 8'd0);
    for (int c = 1; c <= 5; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], sm[c], sm[c]};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL width_zero cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
  endtask

  task automatic test_ignored_trigger;
    logic [31:0] xm, dm, rm;
    logic [3:0]  got, exp_v;
    xm = 32'h0000_038E;
    dm = 32'h0000_2000;
    rm = 32'h0001_C000;
    issue(8'd2, 8'd0, 8'd3);
    for (int c = 1; c <= 16; c++) begin
      next_cyc;
      if (c == 4 || c == 13) issue(8'd3, 8'd3, 8'd1);
      else bus.trigger = 1'b0;
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], 1'b0, xm[c]};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL ignored_trigger cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] sm, xm, dm, rm;
    logic [3:0]  got, exp_v;
    sm = 32'h0000_061E;
    issue(8'd4, 8'd4, 8'd4);
    for (int c = 1; c <= 12; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      reset = (c == 10);
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = (c <= 10) ? {2'b00, sm[c], sm[c]} : 4'b1000;
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_midrun cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
    xm = 32'h0000_0002;
    dm = 32'h0000_0008;
    rm = 32'h0000_0010;
    issue(8'd1, 8'd0, 8'd1);
    for (int c = 1; c <= 4; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], 1'b0, xm[c]};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL after_reset cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
  endtask

  task automatic test_clk_en;
    logic [31:0] xm, dm, rm;
    logic [3:0]  got, exp_v;
    xm = 32'h0000_001E;
    dm = 32'h0000_0200;
    rm = 32'h0000_0C00;
    clk_en = 1'b1;
    issue(8'd1, 8'd0, 8'd2);
    for (int c = 1; c <= 11; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      clk_en = (c % 2 == 0);
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], 1'b0, xm[c]};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL clk_en cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] xm, ym, dm, rm;
    logic [3:0]  got, exp_v;
    xm = 32'h0000_0022;
    ym = 32'h0000_0002;
    dm = 32'h0000_0088;
    rm = 32'h0000_0110;
    issue(8'd1, 8'd1, 8'd1);
    for (int c = 1; c <= 8; c++) begin
      next_cyc;
      if (c == 4) issue(8'd1, 8'd0, 8'd1);
      else bus.trigger = 1'b0;
      got   = {bus.rdy, bus.done, step_y, step_x};
      exp_v = {rm[c], dm[c], ym[c], xm[c]};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b (rdy,done,y,x)", c, got, exp_v);
      end
    end
  endtask

  task automatic test_max_count;
    int xcnt = 0;
    int ycnt = 0;
    int ndone = 0;
    int done_cyc = -1;
    issue(8'd255, 8'd1, 8'd1);
    for (int c = 1; c <= 600; c++) begin
      next_cyc;
      bus.trigger = 1'b0;
      if (step_x) xcnt++;
      if (step_y) ycnt++;
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.rdy && done_cyc > 0) break;
    end
    tests_run++;
    if (xcnt != 255) begin
      tests_failed++;
      $display("FAIL max_count_x: got %0d high cycles expected 255", xcnt);
    end
    tests_run++;
    if (ycnt != 1) begin
      tests_failed++;
      $display("FAIL max_count_y: got %0d high cycles expected 1", ycnt);
    end
    tests_run++;
    if (done_cyc != 511 || ndone != 1) begin
      tests_failed++;
      $display("FAIL max_count_done: got cycle %0d (%0d strobes) expected cycle 511 (1 strobe)", done_cyc, ndone);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_counts;
    test_width_zero;
    test_ignored_trigger;
    test_reset_midrun;
    test_clk_en;
    test_back_to_back;
    test_max_count;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/stepper_ctrl_xy.md
# stepper_ctrl_xy

Slave end of the two-axis stepper control interface: accepts a move command (`pulse_num_x`, `pulse_num_y`, `pulse_width`) from the processor-side master on `trigger` and generates independent step pulse trains on the X and Y driver outputs. Both axes run concurrently. `rdy`/`done` report completion back to the master. Sits between the command processor and the stepper driver pins.

## Interface
- `PULSE_NUM_X_BITS`, default 8: width of the X pulse count.
- `PULSE_NUM_Y_BITS`, default 8: width of the Y pulse count.
- `PULSE_WIDTH_BITS`, default 8: width of the high/low phase length, in `clk_en` ticks.

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  timing tick; phase counters advance only on cycles where it is 1.
- `pulse_num_x`  in  PULSE_NUM_X_BITS  number of X step pulses, unsigned.
- `pulse_num_y`  in  PULSE_NUM_Y_BITS  number of Y step pulses, unsigned.
- `pulse_width`  in  PULSE_WIDTH_BITS  high-phase and low-phase length in ticks.
- `trigger`  in  1  start command; sampled only when `rdy`=1.
- `done`  out  1  one-cycle completion strobe.
- `rdy`  out  1  idle, command may be issued.
- `step_x`  out  1  X step output, registered.
- `step_y`  out  1  Y step output, registered.

## Operation
- FSM states:
  - IDLE: `rdy`=1.
  - RUN: `rdy`=0.
  - DONE: `done`=1, `rdy`=0, lasts exactly 1 cycle.
- Transitions:
  - IDLE→RUN on `trigger`=1. Inputs are latched in the same cycle, so master inputs may change afterwards.
  - IDLE→DONE directly if both latched counts are 0.
  - RUN→DONE when both axes have finished.
  - DONE→IDLE unconditionally.
- Latched `pulse_width`=0 is treated as 1.
- Each pulse is W ticks high followed by W ticks low, a period of 2W ticks.
- Each axis has:
  - a remaining-pulse counter (axis width);
  - a phase counter (PULSE_WIDTH_BITS);
  - a level flag.
- An axis with a count of 0 holds its step output low and is finished immediately.
- On a tick, each unfinished axis increments its phase counter. When the counter reaches W, it resets to 0 and toggles the level. On a high→low toggle the axis decrements its remaining count. An axis is finished after the low phase of its last pulse completes.
- Axes are independent. The shorter axis idles low while the longer one runs.
- `trigger` is ignored in RUN and DONE; there is no queueing.
- Counters never wrap: the maximum count 2^N−1 produces exactly that many pulses.
- Reset in any state:
  - next cycle: IDLE, `rdy`=1, `done`=0, `step_x`=`step_y`=0, all counters 0;
  - any in-progress move is abandoned.

## Timing
- Reset values: `rdy`=1, `done`=0, `step_x`=0, `step_y`=0.
- Timing below assumes `clk_en`=1 and a trigger accepted at cycle 0.
  - `rdy`=0 from cycle 1.
  - Step outputs with count>0 go high at cycle 1.
  - Axis pulse k (k=0..N−1) is high in cycles 2Wk+1 … 2Wk+W and low in cycles 2Wk+W+1 … 2W(k+1).
  - `done`=1 in cycle 2W·max(Nx,Ny)+1; `rdy`=1 from the following cycle.
  - A new trigger is accepted in that cycle, so the back-to-back gap is 2 cycles.
- Both counts 0: `done` in cycle 1, `rdy` in cycle 2.
- With `clk_en` gated, durations scale by ticks. Step edges occur only in the cycle after a tick. The `done` → `rdy` sequence is not gated by `clk_en`.

## Test plan
- Nx=3, Ny=2, W=2, `clk_en`=1, trigger at cycle 0 → `step_x` high in cycles 1–2, 5–6, 9–10; `step_y` high in 1–2, 5–6; `done` in cycle 13 only; `rdy` high from cycle 14.
- Nx=0, Ny=0, W=5 → no step activity; `done` in cycle 1; `rdy` in cycle 2.
- Nx=1, Ny=1, W=0 → both outputs high in cycle 1 only (treated as W=1); `done` in cycle 3.
- Nx=2, Ny=0, W=3; extra triggers with different values at cycles 4 and 13 (RUN and DONE) → both ignored; exactly 2 X pulses; `done` in cycle 13; `rdy` from 14.
- Nx=4, Ny=4, W=4; reset asserted at cycle 10 → cycle 11: `rdy`=1, steps low, no `done`; a fresh trigger (Nx=1, Ny=0, W=1) then runs normally.
- Nx=1, Ny=0, W=2, `clk_en` high every other cycle (even cycles) → `step_x` high for 4 cycles and low for 4 cycles; a single `done` afterwards.
